// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter between the I-cache and D-cache line ports
// and the single L2 cache port. A request is registered into the L2 port
// registers at grant. No combinational path runs from L1 to L2. Responses
// are steered combinationally back to the granted side only.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_pmem_* (address/read/write/wdata in, rdata/resp out)   I-cache side
//   d_pmem_* (address/read/write/wdata in, rdata/resp out)   D-cache side
//   l2_address/l2_read/l2_write/l2_wdata out (registered), l2_rdata/l2_resp in
module l2_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic [ADDR_W-1:0] l2_address,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

    state_t state, state_next;
    logic   last_grant, last_grant_next;  // 0 = I, 1 = D
    logic   i_req, d_req;
    logic   grant_i, grant_d;
    logic   busy;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);

    // On a tie the side that did not win last time is granted.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                grant_d = ~last_grant;
                grant_i = last_grant;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next      = BUSY_D;
                    last_grant_next = 1'b1;
                end else if (grant_i) begin
                    state_next      = BUSY_I;
                    last_grant_next = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_resp) state_next = DRAIN;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // L2 port registers: loaded only at grant, so L1 inputs are ignored while busy.
    // A simultaneous read+write resolves to a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            l2_address <= '0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_wdata   <= '0;
        end else if (grant_d) begin
            l2_address <= {d_pmem_address[ADDR_W-1:4], 4'b0000};
            l2_read    <= d_pmem_read & ~d_pmem_write;
            l2_write   <= d_pmem_write;
            l2_wdata   <= d_pmem_wdata;
        end else if (grant_i) begin
            l2_address <= {i_pmem_address[ADDR_W-1:4], 4'b0000};
            l2_read    <= i_pmem_read & ~i_pmem_write;
            l2_write   <= i_pmem_write;
            l2_wdata   <= i_pmem_wdata;
        end else if (busy && l2_resp) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
        end
    end

    // Response steering: only the granted side sees L2 data and resp.
    always_comb begin
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        unique case (state)
            BUSY_I: begin
                i_pmem_rdata = l2_rdata;
                i_pmem_resp  = l2_resp;
            end
            BUSY_D: begin
                d_pmem_rdata = l2_rdata;
                d_pmem_resp  = l2_resp;
            end
            default: ;
        endcase
    end

    // Illegal op encoding at grant; reported as a warning so simulation continues.
    always_ff @(posedge clk) begin
        if (!rst && grant_d)
            assert (!(d_pmem_read && d_pmem_write))
            else $warning("l2_arbiter: D-cache read and write together, write taken");
        if (!rst && grant_i)
            assert (!(i_pmem_read && i_pmem_write))
            else $warning("l2_arbiter: I-cache read and write together, write taken");
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  i_pmem_address, d_pmem_address, l2_address;
    logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [127:0] i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
    logic         i_pmem_resp, d_pmem_resp;
    logic         l2_read, l2_write, l2_resp;
    logic [127:0] l2_wdata, l2_rdata;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
        .i_pmem_write(i_pmem_write), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    typedef struct {
        logic [15:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] wdata;
        int           len;   // cycles l2_read/l2_write stay high
        int           gap;   // idle cycles before this request, -1 = don't care
    } l2_exp_t;

    typedef struct {
        logic         side;  // 0 = I, 1 = D
        logic [127:0] data;
    } resp_exp_t;

    l2_exp_t   exp_l2[$];
    resp_exp_t exp_resp[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push_l2(input logic [15:0] a, input logic rd, input logic wr,
                           input logic [127:0] wd, input int len, input int gap);
        l2_exp_t e;
        e.addr = a; e.rd = rd; e.wr = wr; e.wdata = wd; e.len = len; e.gap = gap;
        exp_l2.push_back(e);
    endtask

    task automatic push_resp(input logic side, input logic [127:0] data);
        resp_exp_t e;
        e.side = side; e.data = data;
        exp_resp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits (bounded) until the L2 port shows a request; leaves us 1ns after the grant edge.
    task automatic wait_active(output bit ok);
        int waited = 0;
        while (!(l2_read | l2_write) && waited < 50) begin
            tick();
            waited++;
        end
        ok = l2_read | l2_write;
        if (!ok) begin
            n_checks++;
            $display("FAIL l2_request_timeout: no L2 request after %0d cycles, expected one", waited);
        end
    endtask

    // Acts as L2: responds in the lat-th cycle of the transaction.
    task automatic serve(input int lat, input logic [127:0] data);
        bit ok;
        wait_active(ok);
        if (!ok) return;
        repeat (lat - 1) tick();
        l2_rdata = data;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        l2_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Spurious l2_resp while nothing is granted must not reach either L1.
    task automatic stray_resp(input string name);
        l2_rdata = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        l2_resp  = 1'b1;
        @(negedge clk);
        chk({name, "_resp"}, 128'({i_pmem_resp, d_pmem_resp}), 128'd0);
        chk({name, "_rdata"}, i_pmem_rdata | d_pmem_rdata, 128'd0);
        tick();
        l2_resp = 1'b0;
    endtask

    // L2-side monitor: pops an expected request at each new transaction.
    logic    prev_act = 1'b0;
    bit      cur_valid = 1'b0;
    int      run_len = 0;
    int      idle_len = 0;
    l2_exp_t cur;

    always @(negedge clk) begin
        if (l2_read | l2_write) begin
            if (!prev_act) begin
                if (exp_l2.size() == 0) begin
                    cur_valid = 1'b0;
                    n_checks++;
                    $display("FAIL l2_unexpected: got request addr %h rd %b wr %b, expected none",
                             l2_address, l2_read, l2_write);
                end else begin
                    cur = exp_l2.pop_front();
                    cur_valid = 1'b1;
                    chk("l2_address", 128'(l2_address), 128'(cur.addr));
                    chk("l2_op", 128'({l2_read, l2_write}), 128'({cur.rd, cur.wr}));
                    chk("l2_wdata", l2_wdata, cur.wdata);
                    if (cur.gap >= 0) chk("grant_gap", 128'(idle_len), 128'(cur.gap));
                end
                run_len = 1;
            end else begin
                run_len++;
                if (cur_valid) begin
                    chk("l2_hold_addr_op", 128'({l2_address, l2_read, l2_write}),
                        128'({cur.addr, cur.rd, cur.wr}));
                    chk("l2_hold_wdata", l2_wdata, cur.wdata);
                end
            end
        end else begin
            if (prev_act && cur_valid) chk("l2_active_len", 128'(run_len), 128'(cur.len));
            idle_len = prev_act ? 1 : idle_len + 1;
        end
        prev_act = l2_read | l2_write;
    end

    // L1-side monitor: pops an expected response at each resp pulse.
    resp_exp_t re;
    always @(negedge clk) begin
        if (i_pmem_resp | d_pmem_resp) begin
            if (exp_resp.size() == 0) begin
                n_checks++;
                $display("FAIL resp_unexpected: got i_resp %b d_resp %b, expected none",
                         i_pmem_resp, d_pmem_resp);
            end else begin
                re = exp_resp.pop_front();
                chk("resp_side", 128'({i_pmem_resp, d_pmem_resp}), re.side ? 128'd1 : 128'd2);
                chk("resp_rdata", re.side ? d_pmem_rdata : i_pmem_rdata, re.data);
                chk("resp_other_rdata", re.side ? i_pmem_rdata : d_pmem_rdata, 128'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] wd;
        bit           ok;
        i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_address = '0; d_pmem_wdata = '0;
        l2_rdata = '0;
        do_reset();

        // reset state
        chk("rst_l2_op", 128'({l2_read, l2_write}), 128'd0);
        chk("rst_l2_address", 128'(l2_address), 128'd0);
        chk("rst_l2_wdata", l2_wdata, 128'd0);
        chk("rst_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'd0);

        // 1: lone D read, 5-cycle L2 latency
        d_pmem_address = 16'h1234; d_pmem_read = 1'b1;
        push_l2(16'h1230, 1'b1, 1'b0, 128'd0, 5, -1);
        push_resp(1'b1, {16{8'hA5}});
        serve(5, {16{8'hA5}});
        d_pmem_read = 1'b0;
        tick(); tick();

        // 2: tie after reset, D write wins, then I read
        do_reset();
        wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        i_pmem_address = 16'h0040; i_pmem_read = 1'b1; i_pmem_wdata = '0;
        d_pmem_address = 16'h8000; d_pmem_write = 1'b1; d_pmem_wdata = wd;
        push_l2(16'h8000, 1'b0, 1'b1, wd, 3, -1);
        push_l2(16'h0040, 1'b1, 1'b0, 128'd0, 4, 2);
        push_resp(1'b1, 128'h1111);
        push_resp(1'b0, 128'h2222);
        serve(3, 128'h1111);
        d_pmem_write = 1'b0;
        serve(4, 128'h2222);
        i_pmem_read = 1'b0;
        tick(); tick();

        // 3: both requesting continuously, grants alternate D,I,...
        do_reset();
        i_pmem_address = 16'h0100; d_pmem_address = 16'h0200; d_pmem_wdata = '0;
        i_pmem_read = 1'b1; d_pmem_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_l2((k % 2 == 0) ? 16'h0200 : 16'h0100, 1'b1, 1'b0, 128'd0, 2, (k == 0) ? -1 : 2);
            push_resp((k % 2 == 0), 128'(32'hC000 + k));
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 5) i_pmem_read = 1'b1;
            serve(2, 128'(32'hC000 + k));
            if (k == 4) d_pmem_read = 1'b0;
        end
        i_pmem_read = 1'b0;
        tick(); tick();

        // 4: stray resp in IDLE, inputs change while BUSY_D
        do_reset();
        stray_resp("idle_stray");
        wd = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        d_pmem_address = 16'h3456; d_pmem_wdata = wd; d_pmem_read = 1'b1;
        push_l2(16'h3450, 1'b1, 1'b0, wd, 4, -1);
        push_resp(1'b1, 128'h4444);
        wait_active(ok);
        d_pmem_address = 16'hFFFF; d_pmem_wdata = ~wd;
        i_pmem_address = 16'h7777; i_pmem_wdata = ~wd;
        serve(4, 128'h4444);
        d_pmem_read = 1'b0;
        stray_resp("drain_stray");
        tick();

        // 5: reset two cycles into BUSY_I
        do_reset();
        i_pmem_address = 16'h0ABC; i_pmem_wdata = '0; i_pmem_read = 1'b1;
        push_l2(16'h0AB0, 1'b1, 1'b0, 128'd0, 2, -1);
        wait_active(ok);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_l2_op", 128'({l2_read, l2_write}), 128'd0);
        chk("midrst_l2_address", 128'(l2_address), 128'd0);
        chk("midrst_l2_wdata", l2_wdata, 128'd0);
        chk("midrst_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'd0);
        rst = 1'b0; i_pmem_read = 1'b0;
        tick();
        stray_resp("post_rst_stray");
        d_pmem_address = 16'h2220; d_pmem_wdata = '0;
        i_pmem_read = 1'b1; d_pmem_read = 1'b1;
        push_l2(16'h2220, 1'b1, 1'b0, 128'd0, 2, -1);
        push_l2(16'h0AB0, 1'b1, 1'b0, 128'd0, 2, 2);
        push_resp(1'b1, 128'h5151);
        push_resp(1'b0, 128'h5252);
        serve(2, 128'h5151);
        d_pmem_read = 1'b0;
        serve(2, 128'h5252);
        i_pmem_read = 1'b0;
        tick(); tick();

        // 6: D read+write together resolves to a write
        do_reset();
        wd = 128'hFACE_0000_0000_0000_0000_0000_0000_B00C;
        d_pmem_address = 16'h555F; d_pmem_wdata = wd;
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        push_l2(16'h5550, 1'b0, 1'b1, wd, 2, -1);
        push_resp(1'b1, 128'h6666);
        serve(2, 128'h6666);
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        tick(); tick(); tick();

        chk("exp_l2_drained", 128'(exp_l2.size()), 128'd0);
        chk("exp_resp_drained", 128'(exp_resp.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
